// File: rtl/instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_loader
// Brief    : Packs field-level RV32I descriptions into instruction words and
//            streams them into IMEM from a programmable base address.
//            Optional round-trip immediate check: IMMENC_ROUNDTRIP_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder_loader #(
    parameter int MAX_WORDS = 2048,
    parameter int ADDR_W    = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    input  logic [ADDR_W-1:0]            i_base_addr,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [2:0]                   i_fmt,
    input  logic [6:0]                   i_opcode,
    input  logic [4:0]                   i_rd,
    input  logic [4:0]                   i_rs1,
    input  logic [4:0]                   i_rs2,
    input  logic [2:0]                   i_funct3,
    input  logic [6:0]                   i_funct7,
    input  logic [31:0]                  i_imm,
    input  logic                         i_last,
    output logic                         o_wr_en,
    output logic [ADDR_W-1:0]            o_wr_addr,
    output logic [31:0]                  o_wr_data,
    output logic                         o_busy,
    output logic                         o_done,
    output logic [$clog2(MAX_WORDS):0]   o_count,
    output logic                         o_enc_err,
    output logic                         o_ovf,
    output logic                         o_rt_err
);
    localparam int               CNT_W  = $clog2(MAX_WORDS) + 1;
    localparam logic [CNT_W-1:0] c_max  = CNT_W'(MAX_WORDS);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(MAX_WORDS - 1);
    localparam logic [31:0]      c_nop  = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_base;
    logic [CNT_W-1:0]    r_count;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [31:0]         r_wr_data;
    logic                r_enc_err;
    logic                r_ovf;

    logic                w_start;
    logic                w_accept;
    logic                w_at_last;
    logic [ADDR_W-1:0]   w_offset;
    logic [31:0]         w_enc_word;
    logic                w_enc_bad;
    logic                w_fit12, w_fit13, w_fit21;

    assign w_start   = (r_state == S_IDLE) && i_start;
    assign o_ready   = (r_state == S_RUN) && (r_count < c_max);
    assign w_accept  = i_valid && o_ready;
    assign w_at_last = (r_count == c_last);
    // The write index equals the number of words already written.
    assign w_offset  = ADDR_W'({r_count, 2'b00});

    // An immediate survives encoding when all bits above the field are sign copies.
    assign w_fit12 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
    assign w_fit13 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
    assign w_fit21 = (&i_imm[31:20]) | ~(|i_imm[31:20]);

    always_comb begin
        w_enc_word = c_nop;
        w_enc_bad  = 1'b0;
        case (i_fmt)
            3'd0: w_enc_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            3'd1: begin
                w_enc_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
                w_enc_bad  = !w_fit12;
            end
            3'd2: begin
                w_enc_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
                w_enc_bad  = !w_fit12;
            end
            3'd3: begin
                w_enc_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                              i_imm[4:1], i_imm[11], i_opcode};
                w_enc_bad  = !w_fit13 || i_imm[0];
            end
            3'd4: begin
                w_enc_word = {i_imm[31:12], i_rd, i_opcode};
                w_enc_bad  = |i_imm[11:0];
            end
            3'd5: begin
                w_enc_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
                w_enc_bad  = !w_fit21 || i_imm[0];
            end
            default: w_enc_bad = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_accept && (i_last || w_at_last)) w_state_nxt = S_FLUSH;
            S_FLUSH: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_base    <= '0;
            r_count   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_enc_err <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_wr_en <= w_accept;
            if (w_start) begin
                r_base    <= {i_base_addr[ADDR_W-1:2], 2'b00};
                r_count   <= '0;
                r_enc_err <= 1'b0;
                r_ovf     <= 1'b0;
            end
            if (w_accept) begin
                r_wr_data <= w_enc_word;
                r_wr_addr <= r_base + w_offset;
                r_count   <= r_count + 1'b1;
                if (w_enc_bad) r_enc_err <= 1'b1;
                if (w_at_last && !i_last) r_ovf <= 1'b1;
            end
        end
    end

`ifdef IMMENC_ROUNDTRIP_CHECK_EN
    logic [31:0] r_imm;
    logic        r_chk;
    logic        r_rt_err;
    logic [31:0] w_ext;
    logic        w_rt_mis;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_imm    <= '0;
            r_chk    <= 1'b0;
            r_rt_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_imm <= i_imm;
                r_chk <= (i_fmt >= 3'd1) && (i_fmt <= 3'd5);
            end
            if (w_start) begin
                r_rt_err <= 1'b0;
            end else if (w_rt_mis) begin
                r_rt_err <= 1'b1;
            end
        end
    end

    // Same opcode-driven immediate decode as the core.
    always_comb begin
        w_ext = '0;
        case (r_wr_data[6:0])
            7'h03, 7'h13, 7'h67, 7'h73:
                w_ext = {{20{r_wr_data[31]}}, r_wr_data[31:20]};
            7'h23:
                w_ext = {{20{r_wr_data[31]}}, r_wr_data[31:25], r_wr_data[11:7]};
            7'h63:
                w_ext = {{19{r_wr_data[31]}}, r_wr_data[31], r_wr_data[7],
                         r_wr_data[30:25], r_wr_data[11:8], 1'b0};
            7'h37, 7'h17:
                w_ext = {r_wr_data[31:12], 12'b0};
            7'h6F:
                w_ext = {{11{r_wr_data[31]}}, r_wr_data[31], r_wr_data[19:12],
                         r_wr_data[20], r_wr_data[30:21], 1'b0};
            default: w_ext = '0;
        endcase
    end

    assign w_rt_mis = r_wr_en && r_chk && (w_ext != r_imm);
    assign o_rt_err = r_rt_err | w_rt_mis;
`else
    assign o_rt_err = 1'b0;
`endif

    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = (r_state == S_DONE);
    assign o_count   = r_count;
    assign o_enc_err = r_enc_err;
    assign o_ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder_loader
// Brief    : Directed table-driven bench for instr_encoder_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder_loader;
    localparam int MAXW = 4;
    localparam int CW   = $clog2(MAXW) + 1;
`ifdef IMMENC_ROUNDTRIP_CHECK_EN
    localparam logic RT_EN = 1'b1;
`else
    localparam logic RT_EN = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, valid = 1'b0, last = 1'b0;
    logic [31:0]   base = '0, imm = '0;
    logic [2:0]    fmt = '0, f3 = '0;
    logic [6:0]    op = '0, f7 = '0;
    logic [4:0]    rd = '0, rs1 = '0, rs2 = '0;
    logic          ready, wr_en, busy, done, enc_err, ovf, rt_err;
    logic [31:0]   wr_addr, wr_data;
    logic [CW-1:0] count;

    instr_encoder_loader #(.MAX_WORDS(MAXW), .ADDR_W(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_base_addr(base),
        .i_valid(valid), .o_ready(ready), .i_fmt(fmt), .i_opcode(op),
        .i_rd(rd), .i_rs1(rs1), .i_rs2(rs2), .i_funct3(f3), .i_funct7(f7),
        .i_imm(imm), .i_last(last), .o_wr_en(wr_en), .o_wr_addr(wr_addr),
        .o_wr_data(wr_data), .o_busy(busy), .o_done(done), .o_count(count),
        .o_enc_err(enc_err), .o_ovf(ovf), .o_rt_err(rt_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] base;
        logic [31:0] exp_data;
        logic        exp_err;
        logic        exp_rt;
    } vec_t;

    vec_t tbl [14];
    int   n_vec = 0;
    int   n_mis = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s[%0d]: got 0x%08h, want 0x%08h", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input vec_t v);
        fmt = v.fmt; op = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        f3 = v.f3; f7 = v.f7; imm = v.imm;
    endtask

    task automatic do_start(input logic [31:0] b);
        base = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = tbl[i];
        do_start(v.base);
        chk("start_busy", i, busy, 1'b1);
        chk("start_ready", i, ready, 1'b1);
        chk("start_clr_err", i, enc_err, 1'b0);
        put(v); valid = 1'b1; last = 1'b1;
        tick();
        valid = 1'b0; last = 1'b0;
        chk("wr_en", i, wr_en, 1'b1);
        chk("wr_addr", i, wr_addr, v.base & 32'hFFFF_FFFC);
        chk("wr_data", i, wr_data, v.exp_data);
        chk("enc_err", i, enc_err, v.exp_err);
        chk("rt_err", i, rt_err, v.exp_rt & RT_EN);
        chk("count", i, 32'(count), 32'd1);
        tick();
        chk("done", i, done, 1'b1);
        chk("done_wr_en", i, wr_en, 1'b0);
        tick();
        chk("idle_done", i, done, 1'b0);
        chk("idle_busy", i, busy, 1'b0);
        chk("sticky_err", i, enc_err, v.exp_err);
        chk("sticky_rt", i, rt_err, v.exp_rt & RT_EN);
    endtask

    initial begin
        //             fmt   op     rd  rs1 rs2 f3 f7     imm            base           data           err   rt
        tbl[0]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,         32'h0000_0100, 32'h0050_0093, 1'b0, 1'b0};
        tbl[1]  = '{3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,         32'h0000_0140, 32'h0020_A423, 1'b0, 1'b0};
        tbl[2]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'h0000_0180, 32'hFE00_0EE3, 1'b0, 1'b0};
        tbl[3]  = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,      32'h0000_01C0, 32'h0010_00EF, 1'b0, 1'b0};
        tbl[4]  = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h0000_0203, 32'h1234_52B7, 1'b0, 1'b0};
        tbl[5]  = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001, 32'h0000_0240, 32'h1234_52B7, 1'b1, 1'b1};
        tbl[6]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,      32'h0000_0280, 32'h8000_0093, 1'b1, 1'b1};
        tbl[7]  = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3,         32'h0000_02C0, 32'h0000_0163, 1'b1, 1'b1};
        tbl[8]  = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,         32'h0000_0300, 32'h0020_81B3, 1'b0, 1'b0};
        tbl[9]  = '{3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,         32'h0000_0340, 32'h0000_0013, 1'b1, 1'b0};
        tbl[10] = '{3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0,         32'h0000_0380, 32'h4020_81B3, 1'b0, 1'b0};
        tbl[11] = '{3'd1, 7'h13, 5'd2, 5'd1, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800, 32'h0000_03C0, 32'h8000_8113, 1'b0, 1'b0};
        tbl[12] = '{3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF0_0000, 32'h0000_0400, 32'h8000_006F, 1'b0, 1'b0};
        tbl[13] = '{3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_0FFE, 32'h0000_0440, 32'h7E00_0FE3, 1'b0, 1'b0};

        #1;
        chk("rst_wr_en", 0, wr_en, 1'b0);
        chk("rst_busy", 0, busy, 1'b0);
        chk("rst_ready", 0, ready, 1'b0);
        chk("rst_count", 0, 32'(count), 32'd0);
        chk("rst_flags", 0, {29'd0, enc_err, ovf, rt_err}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Valid while idle must not produce a write.
        put(tbl[0]); valid = 1'b1;
        tick();
        chk("idle_valid_ready", 0, ready, 1'b0);
        tick();
        chk("idle_valid_wr", 0, wr_en, 1'b0);
        valid = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(i);

        // Back-to-back S/B/J across the address wrap; a start mid-run is ignored.
        do_start(32'hFFFF_FFF8);
        for (int k = 0; k < 3; k++) begin
            put(tbl[k + 1]);
            valid = 1'b1;
            last  = (k == 2);
            start = (k == 1);
            base  = (k == 1) ? 32'h0000_5550 : 32'hFFFF_FFF8;
            chk("b2b_ready", k, ready, 1'b1);
            tick();
            chk("b2b_wr_en", k, wr_en, 1'b1);
            chk("b2b_addr", k, wr_addr, 32'hFFFF_FFF8 + 32'(4 * k));
            chk("b2b_data", k, wr_data, tbl[k + 1].exp_data);
            chk("b2b_count", k, 32'(count), 32'(k + 1));
            chk("b2b_err", k, enc_err, 1'b0);
        end
        valid = 1'b0; last = 1'b0; start = 1'b0;
        tick();
        chk("b2b_done", 0, done, 1'b1);
        tick();

        // Overflow: six bundles without last against a four-word limit.
        begin
            int nwr;
            int ndone;
            nwr = 0;
            ndone = 0;
            do_start(32'h0000_0800);
            for (int k = 0; k < 6; k++) begin
                put(tbl[0]); valid = 1'b1; last = 1'b0;
                chk("ovf_ready", k, ready, (k < MAXW));
                tick();
                if (wr_en) begin
                    chk("ovf_addr", nwr, wr_addr, 32'h0000_0800 + 32'(4 * nwr));
                    nwr++;
                end
                if (done) ndone++;
            end
            valid = 1'b0;
            tick();
            chk("ovf_writes", 0, 32'(nwr), 32'd4);
            chk("ovf_done_pulses", 0, 32'(ndone), 32'd1);
            chk("ovf_flag", 0, ovf, 1'b1);
            chk("ovf_count", 0, 32'(count), 32'd4);
            chk("ovf_wr_idle", 0, wr_en, 1'b0);
        end

        // Next start clears the sticky overflow flag.
        do_start(32'h0000_0900);
        chk("ovf_clear", 0, ovf, 1'b0);
        put(tbl[0]); valid = 1'b1; last = 1'b1;
        tick();
        valid = 1'b0; last = 1'b0;
        tick();
        tick();

        // Reset during the cycle after an accept.
        do_start(32'h0000_0300);
        put(tbl[0]); valid = 1'b1; last = 1'b0;
        tick();
        valid = 1'b0;
        chk("pre_rst_wr_en", 0, wr_en, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", 0, wr_en, 1'b0);
        chk("mid_rst_busy", 0, busy, 1'b0);
        chk("mid_rst_count", 0, 32'(count), 32'd0);
        chk("mid_rst_addr", 0, wr_addr, 32'd0);
        chk("mid_rst_data", 0, wr_data, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_start(32'h0000_4000);
        put(tbl[1]); valid = 1'b1; last = 1'b1;
        tick();
        valid = 1'b0; last = 1'b0;
        chk("restart_addr", 0, wr_addr, 32'h0000_4000);
        chk("restart_data", 0, wr_data, tbl[1].exp_data);
        chk("restart_count", 0, 32'(count), 32'd1);
        tick();
        chk("restart_done", 0, done, 1'b1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
`default_nettype wire
